// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] RESET_PC = 8'h00;
  localparam logic [PC_WIDTH-1:0] PC_INC   = 8'd1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} fetch_state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch response that arrives while the pipe is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        clear,
  input  fetch_slot_t din,
  output logic        full,
  output fetch_slot_t dout
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, imem req/ack handshake, skid buffer, IF/ID outputs.
module if_fetch_unit
  import fetch_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   hazard,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   valid_out
);

  fetch_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
  logic                   req_q, req_d;
  logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;

  logic        skid_load, skid_clear, skid_full;
  fetch_slot_t skid_din, skid_dout;

  assign skid_din = '{pc: req_addr_q, instr: imem_rdata};

  fetch_skid_buf u_skid (
    .CLK   (CLK),
    .RST   (RST),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (skid_din),
    .full  (skid_full),
    .dout  (skid_dout)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    req_d      = req_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A late ack from an abandoned request is ignored here.
        state_d    = REQ;
        req_d      = 1'b1;
        req_addr_d = pc_q;
        if (branch_taken) begin
          pc_d       = branch_target;
          req_addr_d = branch_target;
        end
      end
      REQ: begin
        if (branch_taken) begin
          pc_d       = branch_target;
          valid_d    = 1'b0;
          skid_clear = 1'b1;
          if (imem_ack) begin
            req_addr_d = branch_target;
          end else begin
            state_d = FLUSH;
          end
        end else if (imem_ack && !hazard) begin
          pc_out_d   = req_addr_q;
          instr_d    = imem_rdata;
          valid_d    = 1'b1;
          pc_d       = pc_q + PC_INC;
          req_addr_d = req_addr_q + PC_INC;
        end else if (imem_ack) begin
          skid_load = 1'b1;
          pc_d      = pc_q + PC_INC;
          req_d     = 1'b0;
          state_d   = HOLD;
        end else if (!hazard) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d       = branch_target;
          valid_d    = 1'b0;
          skid_clear = 1'b1;
          req_d      = 1'b1;
          req_addr_d = branch_target;
          state_d    = REQ;
        end else if (!hazard) begin
          pc_out_d   = skid_dout.pc;
          instr_d    = skid_dout.instr;
          valid_d    = skid_full;
          skid_clear = 1'b1;
          req_d      = 1'b1;
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      FLUSH: begin
        // Old request stays on the bus until acked; its data is dropped.
        valid_d = 1'b0;
        if (branch_taken) begin
          pc_d = branch_target;
        end
        if (imem_ack) begin
          req_addr_d = branch_taken ? branch_target : pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      pc_out_q   <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = req_addr_q;
  assign pc_out    = pc_out_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit; each vector gives inputs and post-edge outputs.
module tb_if_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        hazard = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [7:0]  pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  if_fetch_unit dut (
    .CLK           (CLK),
    .RST           (RST),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .valid_out     (valid_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        haz;
    logic        br;
    logic [7:0]  tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [7:0]  addr;
    logic        valid;
    logic [7:0]  pc;
    logic [31:0] instr;
  } vec_t;

  int checks = 0;
  int passes = 0;

  function automatic vec_t mk(input logic rst, input logic haz, input logic br,
                              input logic [7:0] tgt, input logic ack, input logic [31:0] rdata,
                              input logic req, input logic [7:0] addr, input logic valid,
                              input logic [7:0] pc, input logic [31:0] instr);
    vec_t v;
    v.rst = rst; v.haz = haz; v.br = br; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic apply(input vec_t v, input string tag);
    RST = v.rst; hazard = v.haz; branch_taken = v.br; branch_target = v.tgt;
    imem_ack = v.ack; imem_rdata = v.rdata;
    @(posedge CLK);
    #1;
    chk({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, v.req});
    chk({tag, " imem_addr"}, {24'b0, imem_addr}, {24'b0, v.addr});
    chk({tag, " valid_out"}, {31'b0, valid_out}, {31'b0, v.valid});
    chk({tag, " pc_out"}, {24'b0, pc_out}, {24'b0, v.pc});
    chk({tag, " instr_out"}, instr_out, v.instr);
  endtask

  vec_t vecs[$];

  initial begin
    //               rst haz br  tgt    ack rdata          req addr   vld pc     instr
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 0, 8'h00, 32'h0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h00, 0, 8'h00, 32'h0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000000,  1, 8'h01, 1, 8'h00, 32'hA0000000));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000001,  1, 8'h02, 1, 8'h01, 32'hA0000001));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000002,  1, 8'h03, 1, 8'h02, 32'hA0000002));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000003,  1, 8'h04, 1, 8'h03, 32'hA0000003));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000004,  1, 8'h05, 1, 8'h04, 32'hA0000004));
    // ack for 05 delayed three cycles
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h05, 0, 8'h04, 32'hA0000004));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h05, 0, 8'h04, 32'hA0000004));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h05, 0, 8'h04, 32'hA0000004));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000005,  1, 8'h06, 1, 8'h05, 32'hA0000005));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000006,  1, 8'h07, 1, 8'h06, 32'hA0000006));
    // ack for 07 under hazard goes to the skid buffer
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 32'hA0000007,  0, 8'h07, 1, 8'h06, 32'hA0000006));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 32'h0,         0, 8'h07, 1, 8'h06, 32'hA0000006));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 32'h0,         0, 8'h07, 1, 8'h06, 32'hA0000006));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 32'h0,         0, 8'h07, 1, 8'h06, 32'hA0000006));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h08, 1, 8'h07, 32'hA0000007));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000008,  1, 8'h09, 1, 8'h08, 32'hA0000008));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000009,  1, 8'h0A, 1, 8'h09, 32'hA0000009));
    // branch to 40 while 0A is outstanding
    vecs.push_back(mk(0, 0, 1, 8'h40, 0, 32'h0,         1, 8'h0A, 0, 8'h09, 32'hA0000009));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h0A, 0, 8'h09, 32'hA0000009));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hDEADBEEF,  1, 8'h40, 0, 8'h09, 32'hA0000009));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000040,  1, 8'h41, 1, 8'h40, 32'hA0000040));
    // branch with same-cycle ack, then wrap FE, FF, 00
    vecs.push_back(mk(0, 0, 1, 8'hFE, 1, 32'hA0000041,  1, 8'hFE, 0, 8'h40, 32'hA0000040));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA00000FE,  1, 8'hFF, 1, 8'hFE, 32'hA00000FE));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA00000FF,  1, 8'h00, 1, 8'hFF, 32'hA00000FF));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000000,  1, 8'h01, 1, 8'h00, 32'hA0000000));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 32'h0,         1, 8'h01, 0, 8'h00, 32'hA0000000));
    // reset mid-request, late ack ignored in IDLE
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 32'h0,         0, 8'h00, 0, 8'h00, 32'h0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'h12345678,  1, 8'h00, 0, 8'h00, 32'h0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 32'hA0000000,  1, 8'h01, 1, 8'h00, 32'hA0000000));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Branch while holding a skidded response, then repeated branches during flush
    apply(mk(0, 1, 0, 8'h00, 1, 32'hA0000001, 0, 8'h01, 1, 8'h00, 32'hA0000000), "hold_enter");
    apply(mk(0, 1, 1, 8'h20, 0, 32'h0,        1, 8'h20, 0, 8'h00, 32'hA0000000), "hold_branch");
    apply(mk(0, 0, 1, 8'h30, 0, 32'h0,        1, 8'h20, 0, 8'h00, 32'hA0000000), "flush_enter");
    apply(mk(0, 0, 1, 8'h50, 0, 32'h0,        1, 8'h20, 0, 8'h00, 32'hA0000000), "flush_rebranch");
    apply(mk(0, 0, 0, 8'h00, 1, 32'hBAD0BAD0, 1, 8'h50, 0, 8'h00, 32'hA0000000), "flush_ack");
    apply(mk(0, 0, 0, 8'h00, 1, 32'hA0000050, 1, 8'h51, 1, 8'h50, 32'hA0000050), "after_flush");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that generates the 8-bit PC, runs a request/acknowledge handshake with instruction memory, and presents PC, instruction and valid flag to the IF/ID pipeline register.
- valid_out drives the IF/ID wb_ff_in input.
- The shared hazard signal stalls it together with IF/ID.
- branch_taken from the execute stage redirects it; a 1-entry skid buffer absorbs memory responses that arrive during a stall.

Parameters:
- PC_WIDTH, 8, width of PC and memory address.
- INSTR_WIDTH, 32, width of instruction word.
- RESET_PC, 8'h00, PC value after reset.
- PC_INC, 1, PC increment per instruction (word-addressed memory).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- hazard  in  1  stall from hazard unit; the output slot is consumed on every edge where hazard=0.
- branch_taken  in  1  single-cycle redirect request.
- branch_target  in  PC_WIDTH  redirect address, valid with branch_taken.
- imem_req  out  1  memory request valid.
- imem_addr  out  PC_WIDTH  request address.
- imem_ack  in  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  INSTR_WIDTH  fetched instruction.
- pc_out  out  PC_WIDTH  PC of the presented instruction; feeds IF/ID PC_in.
- instr_out  out  INSTR_WIDTH  presented instruction.
- valid_out  out  1  presented slot holds a real instruction; feeds IF/ID wb_ff_in.

Behaviour:
- Reset is synchronous, active-high, on CLK. While RST=1 at an edge:
  - pc_reg=RESET_PC; req_addr=RESET_PC; imem_req=0.
  - pc_out=0, instr_out=0, valid_out=0.
  - skid empty; state=IDLE.
  - Asserting RST mid-request drops imem_req at the next edge. Memory must ignore an ack for an abandoned request; a late ack is ignored in IDLE.
- States: IDLE, REQ, HOLD, FLUSH. All outputs are registered.
- IDLE: at the first edge with RST=0, go to REQ with imem_req=1 and imem_addr=pc_reg.
- Handshake rules:
  - While imem_req=1, imem_addr stays stable until the cycle of imem_ack.
  - At most one request is outstanding.
  - Best-case throughput is 1 instruction/cycle: ack and the next request occur in back-to-back cycles.
- REQ, ack with hazard=0:
  - Next edge: pc_out=req_addr, instr_out=imem_rdata, valid_out=1.
  - pc_reg and req_addr advance by PC_INC; imem_req stays 1.
  - Fetch-to-output latency is 1 cycle after ack.
- REQ, no ack, hazard=0: valid_out<=0 (bubble) at the edge; pc_out/instr_out keep their last values.
- REQ, ack with hazard=1:
  - Write {req_addr, imem_rdata} into the skid buffer; pc_reg advances.
  - imem_req<=0; go to HOLD.
  - Output registers are unchanged.
- REQ, no ack, hazard=1: outputs held and request held.
- HOLD:
  - imem_req=0; outputs held while hazard=1.
  - At the first edge with hazard=0, outputs load from the skid buffer (valid_out=1), the skid empties, imem_req<=1 with imem_addr=pc_reg, and the state returns to REQ.
- Branch (branch_taken=1 at an edge) has priority over hazard and over ack data:
  - pc_reg<=branch_target; valid_out<=0; skid cleared.
  - If a request is outstanding without ack this cycle, go to FLUSH: keep imem_req=1 at the old address until ack, discard that data, then go to REQ at pc_reg.
  - If ack is in the same cycle as the branch, discard the data; next cycle go to REQ with imem_addr=branch_target.
  - If in HOLD, discard the skid and go to REQ at the target.
- A branch during FLUSH overwrites pc_reg with the newest target and stays in FLUSH.
- Arithmetic: the PC is unsigned modulo 2^PC_WIDTH, so 8'hFF + 1 = 8'h00 with no flag.
- While hazard=1, pc_out, instr_out and valid_out never change except on a branch, which clears valid_out.

Decomposition:
- Package fetch_pkg holds:
  - the fetch_state_t enum {IDLE, REQ, HOLD, FLUSH};
  - constants RESET_PC and PC_INC;
  - the typedef fetch_slot_t {pc, instr}.
- Sub-module fetch_skid_buf: 1-entry register with load, clear, full flag and data out. All other logic stays in if_fetch_unit.

Test Plan:
- Reset then ack every cycle, hazard=0 -> imem_addr 00,01,02...; valid_out=1 one cycle after each ack with pc_out=00,01,02 and instr_out matching rdata.
- Ack delayed by 3 cycles at addr 05 -> imem_addr stays 05 for 4 cycles; valid_out=0 for those cycles; pc_out=05 on the cycle after ack.
- hazard=1 for 4 cycles while ack arrives for addr 07 -> outputs frozen at pc_out=06; imem_req drops; on hazard release pc_out=07 from skid, then a request at 08.
- branch_taken with target 8'h40 while the request for 0A is unacked -> valid_out=0; 0A stays on imem_addr until ack; that data is discarded; next request is addr 40; pc_out=40 follows.
- Run from 8'hFE -> fetch sequence FE, FF, 00 with no glitch; RST asserted mid-request -> imem_req=0 and valid_out=0 at the next edge, restart at RESET_PC.
